// File: rtl/lvds_tx_pkg.sv
// Shared types and constants for the LVDS transmit serializer.
// Contents:
//   state_t              - OFF / SYNC / RUN link state, 2 bits
//   DEFAULT_IDLE_PATTERN - framing word sent while training or when no data is available
//   cnt_width()          - width of a counter that must hold the values 0..n-1
package lvds_tx_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_SYNC = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 10;
    localparam logic [DEFAULT_WIDTH-1:0] DEFAULT_IDLE_PATTERN = 10'b1111100000;

    // Never returns less than one bit, so single-value counters still synthesize.
    function automatic int cnt_width(input int n_values);
        return (n_values <= 2) ? 1 : $clog2(n_values);
    endfunction

endpackage

// File: rtl/lvds_tx_shifter.sv
// Word shift register and bit counter for the LVDS transmit path.
// Ports:
//   clk, rst      - serial bit clock, asynchronous active-high reset
//   i_active      - link is not OFF (qualifies FRAME and boundary)
//   i_clear       - zero the shift register and counter
//   i_load        - load i_load_word and restart the counter (word boundary)
//   i_shift       - shift left one bit and advance the counter
//   i_load_word   - next word to transmit
//   o_dout        - serial bit, equal to the MSB of the shift register
//   o_frame       - DOUT is carrying the first bit of a word
//   o_boundary    - DOUT is carrying the last bit of a word
module lvds_tx_shifter
    import lvds_tx_pkg::*;
#(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_active,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_load_word,
    output logic             o_dout,
    output logic             o_frame,
    output logic             o_boundary
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] r_sr;
    logic [CNT_W-1:0] r_cnt;

    // Clear wins over load, load wins over shift; with none asserted the state holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr  <= '0;
            r_cnt <= '0;
        end else if (i_clear) begin
            r_sr  <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_sr  <= i_load_word;
            r_cnt <= '0;
        end else if (i_shift) begin
            r_sr  <= {r_sr[WIDTH-2:0], 1'b0};
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_dout     = r_sr[WIDTH-1];
    assign o_frame    = i_active & (r_cnt == '0);
    assign o_boundary = i_active & (r_cnt == CNT_LAST);

endmodule

// File: rtl/lvds_tx_serializer.sv
// Parallel-to-serial LVDS transmit stage. Words arrive on a valid/ready
// handshake and are shifted out MSB-first, one bit per clock, after a
// preamble of TRAIN_WORDS idle words. Gaps are filled with the idle
// word and flagged on the sticky UNDERRUN output.
// Ports:
//   C          - bit clock
//   CLR        - asynchronous active-high reset
//   TX_EN      - transmitter enable; low forces the link OFF at the next edge
//   DIN        - parallel data word
//   DIN_VALID  - DIN holds a word
//   DIN_READY  - word accepted on an edge where DIN_VALID & DIN_READY
//   DOUT       - registered serial bit (drives the OBUFDS I input)
//   FRAME      - DOUT carries the first bit of a word
//   UNDERRUN   - sticky: idle word inserted in RUN for lack of data
module lvds_tx_serializer
    import lvds_tx_pkg::*;
#(
    parameter int               WIDTH        = 10,
    parameter logic [WIDTH-1:0] IDLE_PATTERN = WIDTH'(DEFAULT_IDLE_PATTERN),
    parameter int               TRAIN_WORDS  = 16
) (
    input  logic             C,
    input  logic             CLR,
    input  logic             TX_EN,
    input  logic [WIDTH-1:0] DIN,
    input  logic             DIN_VALID,
    output logic             DIN_READY,
    output logic             DOUT,
    output logic             FRAME,
    output logic             UNDERRUN
);

    localparam int TCNT_W = cnt_width(TRAIN_WORDS);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TRAIN_WORDS - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_hold;
    logic               r_hold_v;
    logic [TCNT_W-1:0]  r_tcnt;
    logic               r_underrun;

    logic               w_active;
    logic               w_boundary;
    logic               w_last_train;
    logic               w_din_ready;
    logic               w_accept;
    logic               w_clear;
    logic               w_load;
    logic               w_shift;
    logic [WIDTH-1:0]   w_load_word;

    assign w_active     = (r_state != ST_OFF);
    assign w_last_train = (r_tcnt == TCNT_LAST);
    assign w_din_ready  = (r_state == ST_RUN) & TX_EN & ~r_hold_v;
    assign w_accept     = DIN_VALID & w_din_ready;

    // State register
    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            r_state <= ST_OFF;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_OFF:  if (TX_EN) w_state_next = ST_SYNC;
            ST_SYNC: begin
                if (!TX_EN)
                    w_state_next = ST_OFF;
                else if (w_boundary && w_last_train)
                    w_state_next = ST_RUN;
            end
            ST_RUN:  if (!TX_EN) w_state_next = ST_OFF;
            default: w_state_next = ST_OFF;
        endcase
    end

    // Output / shifter-control logic. At a RUN boundary the held word has
    // priority, then a same-edge bypass of DIN, then an idle fill.
    always_comb begin
        w_clear     = 1'b0;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_load_word = IDLE_PATTERN;
        case (r_state)
            ST_OFF: begin
                if (TX_EN) w_load  = 1'b1;
                else       w_clear = 1'b1;
            end
            ST_SYNC: begin
                if (!TX_EN)          w_clear = 1'b1;
                else if (w_boundary) w_load  = 1'b1;
                else                 w_shift = 1'b1;
            end
            ST_RUN: begin
                if (!TX_EN) begin
                    w_clear = 1'b1;
                end else if (w_boundary) begin
                    w_load = 1'b1;
                    if (r_hold_v)
                        w_load_word = r_hold;
                    else if (w_accept)
                        w_load_word = DIN;
                end else begin
                    w_shift = 1'b1;
                end
            end
            default: w_clear = 1'b1;
        endcase
    end

    // Training counter, holding register and underrun flag. Leaving the
    // enabled states discards any held word so a restart begins clean.
    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            r_tcnt     <= '0;
            r_hold     <= '0;
            r_hold_v   <= 1'b0;
            r_underrun <= 1'b0;
        end else if (!TX_EN || (r_state == ST_OFF)) begin
            r_tcnt     <= '0;
            r_hold_v   <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            if ((r_state == ST_SYNC) && w_boundary && !w_last_train)
                r_tcnt <= r_tcnt + 1'b1;
            if (r_state == ST_RUN) begin
                if (w_boundary) begin
                    if (r_hold_v)
                        r_hold_v <= 1'b0;
                    else if (!w_accept)
                        r_underrun <= 1'b1;
                end else if (w_accept) begin
                    r_hold   <= DIN;
                    r_hold_v <= 1'b1;
                end
            end
        end
    end

    lvds_tx_shifter #(
        .WIDTH (WIDTH)
    ) u_shifter (
        .clk         (C),
        .rst         (CLR),
        .i_active    (w_active),
        .i_clear     (w_clear),
        .i_load      (w_load),
        .i_shift     (w_shift),
        .i_load_word (w_load_word),
        .o_dout      (DOUT),
        .o_frame     (FRAME),
        .o_boundary  (w_boundary)
    );

    assign DIN_READY = w_din_ready;
    assign UNDERRUN  = r_underrun;

endmodule

// File: tb/tb_lvds_tx_serializer.sv
module tb_lvds_tx_serializer;

    localparam int WIDTH = 10;
    localparam logic [WIDTH-1:0] IDLE = 10'h3E0;

    logic             C;
    logic             CLR;
    logic             TX_EN;
    logic [WIDTH-1:0] DIN;
    logic             DIN_VALID;
    logic             DIN_READY;
    logic             DOUT;
    logic             FRAME;
    logic             UNDERRUN;

    int tests_run    = 0;
    int tests_failed = 0;

    // Source queue and per-edge logs; log index k = values just after edge e_k.
    logic [WIDTH-1:0] tx_q[$];
    bit dout_log[$];
    bit frame_log[$];
    bit ready_log[$];
    bit und_log[$];

    lvds_tx_serializer #(
        .WIDTH        (WIDTH),
        .IDLE_PATTERN (IDLE),
        .TRAIN_WORDS  (2)
    ) dut (
        .C         (C),
        .CLR       (CLR),
        .TX_EN     (TX_EN),
        .DIN       (DIN),
        .DIN_VALID (DIN_VALID),
        .DIN_READY (DIN_READY),
        .DOUT      (DOUT),
        .FRAME     (FRAME),
        .UNDERRUN  (UNDERRUN)
    );

    initial C = 1'b0;
    always #5 C = ~C;

    function automatic logic [WIDTH-1:0] word_at(input int s);
        logic [WIDTH-1:0] w;
        w = '0;
        for (int i = 0; i < WIDTH; i++)
            w[WIDTH-1-i] = dout_log[s+i];
        return w;
    endfunction

    // One edge per iteration: present the queue head, note whether this
    // edge completes a handshake, then record outputs 1 time unit later.
    task automatic run_edges(input int n);
        bit acc;
        for (int i = 0; i < n; i++) begin
            if (tx_q.size() > 0) begin
                DIN       = tx_q[0];
                DIN_VALID = 1'b1;
            end else begin
                DIN_VALID = 1'b0;
            end
            acc = DIN_VALID && DIN_READY;
            @(posedge C);
            #1;
            if (acc) void'(tx_q.pop_front());
            dout_log.push_back(DOUT);
            frame_log.push_back(FRAME);
            ready_log.push_back(DIN_READY);
            und_log.push_back(UNDERRUN);
        end
    endtask

    task automatic enable_link();
        dout_log.delete();
        frame_log.delete();
        ready_log.delete();
        und_log.delete();
        TX_EN = 1'b1;
        run_edges(21);
    endtask

    task automatic start_link();
        CLR       = 1'b1;
        TX_EN     = 1'b0;
        DIN_VALID = 1'b0;
        tx_q.delete();
        @(posedge C);
        #1;
        CLR = 1'b0;
        @(posedge C);
        #1;
        enable_link();
    endtask

    task automatic test_reset();
        CLR = 1'b1; TX_EN = 1'b0; DIN = '0; DIN_VALID = 1'b0;
        #2;
        tests_run++;
        if ({DOUT, FRAME, DIN_READY, UNDERRUN} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %b want 0000", {DOUT, FRAME, DIN_READY, UNDERRUN});
        end
        $display("[TB] reset: outputs=%b", {DOUT, FRAME, DIN_READY, UNDERRUN});
    endtask

    task automatic test_preamble();
        start_link();
        tests_run++;
        if (word_at(0) !== IDLE) begin
            tests_failed++;
            $display("FAIL preamble_w0: got %h want %h", word_at(0), IDLE);
        end
        tests_run++;
        if (word_at(10) !== IDLE) begin
            tests_failed++;
            $display("FAIL preamble_w1: got %h want %h", word_at(10), IDLE);
        end
        for (int k = 0; k <= 20; k++) begin
            tests_run++;
            if (frame_log[k] !== ((k % 10) == 0)) begin
                tests_failed++;
                $display("FAIL preamble_frame[%0d]: got %b want %b", k, frame_log[k], (k % 10) == 0);
            end
        end
        tests_run++;
        if (ready_log[19] !== 1'b0 || ready_log[20] !== 1'b1) begin
            tests_failed++;
            $display("FAIL preamble_ready: got e19=%b e20=%b want 0 1", ready_log[19], ready_log[20]);
        end
        tests_run++;
        if (dout_log[20] !== 1'b1) begin
            tests_failed++;
            $display("FAIL preamble_third_idle: got %b want 1", dout_log[20]);
        end
        $display("[TB] preamble: w0=%h w1=%h ready@e20=%b", word_at(0), word_at(10), ready_log[20]);
    endtask

    task automatic test_back_to_back();
        start_link();
        tx_q = '{10'h2AA, 10'h155};
        run_edges(29);
        tests_run++;
        if (word_at(30) !== 10'h2AA) begin
            tests_failed++;
            $display("FAIL b2b_w0: got %h want 2aa", word_at(30));
        end
        tests_run++;
        if (word_at(40) !== 10'h155) begin
            tests_failed++;
            $display("FAIL b2b_w1: got %h want 155", word_at(40));
        end
        tests_run++;
        if (frame_log[30] !== 1'b1 || frame_log[40] !== 1'b1 || frame_log[35] !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_frame: got e30=%b e35=%b e40=%b want 1 0 1", frame_log[30], frame_log[35], frame_log[40]);
        end
        tests_run++;
        if (und_log[49] !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_underrun: got %b want 0", und_log[49]);
        end
        $display("[TB] back_to_back: w0=%h w1=%h underrun=%b", word_at(30), word_at(40), und_log[49]);
    endtask

    task automatic test_underrun();
        start_link();
        tx_q = '{10'h2AA};
        run_edges(40);
        tests_run++;
        if (word_at(30) !== 10'h2AA) begin
            tests_failed++;
            $display("FAIL underrun_data: got %h want 2aa", word_at(30));
        end
        tests_run++;
        if (word_at(40) !== IDLE) begin
            tests_failed++;
            $display("FAIL underrun_fill: got %h want %h", word_at(40), IDLE);
        end
        tests_run++;
        if (und_log[39] !== 1'b0 || und_log[40] !== 1'b1 || und_log[60] !== 1'b1) begin
            tests_failed++;
            $display("FAIL underrun_flag: got e39=%b e40=%b e60=%b want 0 1 1", und_log[39], und_log[40], und_log[60]);
        end
        $display("[TB] underrun: data=%h fill=%h flag=%b", word_at(30), word_at(40), und_log[60]);
    endtask

    task automatic test_hold_full();
        start_link();
        tx_q = '{10'h123, 10'h0F0, 10'h3C3};
        run_edges(39);
        tests_run++;
        if (ready_log[25] !== 1'b0 || ready_log[29] !== 1'b0 || ready_log[30] !== 1'b1) begin
            tests_failed++;
            $display("FAIL hold_ready: got e25=%b e29=%b e30=%b want 0 0 1", ready_log[25], ready_log[29], ready_log[30]);
        end
        tests_run++;
        if (word_at(30) !== 10'h123 || word_at(40) !== 10'h0F0 || word_at(50) !== 10'h3C3) begin
            tests_failed++;
            $display("FAIL hold_order: got %h %h %h want 123 0f0 3c3", word_at(30), word_at(40), word_at(50));
        end
        tests_run++;
        if (und_log[59] !== 1'b0) begin
            tests_failed++;
            $display("FAIL hold_underrun: got %b want 0", und_log[59]);
        end
        $display("[TB] hold_full: words=%h %h %h", word_at(30), word_at(40), word_at(50));
    endtask

    task automatic test_disable();
        start_link();
        tx_q = '{10'h2AA, 10'h155};
        run_edges(14);
        tests_run++;
        if (ready_log[34] !== 1'b0) begin
            tests_failed++;
            $display("FAIL disable_holdfull: got ready %b want 0", ready_log[34]);
        end
        TX_EN     = 1'b0;
        DIN_VALID = 1'b0;
        tx_q.delete();
        @(posedge C);
        #1;
        tests_run++;
        if ({DOUT, FRAME, DIN_READY, UNDERRUN} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL disable_outputs: got %b want 0000", {DOUT, FRAME, DIN_READY, UNDERRUN});
        end
        repeat (3) @(posedge C);
        #1;
        tests_run++;
        if ({DOUT, FRAME} !== 2'b00) begin
            tests_failed++;
            $display("FAIL disable_idle: got %b want 00", {DOUT, FRAME});
        end
        enable_link();
        run_edges(19);
        tests_run++;
        if (word_at(0) !== IDLE || word_at(10) !== IDLE || ready_log[19] !== 1'b0 || ready_log[20] !== 1'b1) begin
            tests_failed++;
            $display("FAIL disable_retrain: got %h %h ready %b%b want %h %h 01", word_at(0), word_at(10), ready_log[19], ready_log[20], IDLE, IDLE);
        end
        tests_run++;
        if (word_at(30) !== IDLE || und_log[30] !== 1'b1) begin
            tests_failed++;
            $display("FAIL disable_hold_lost: got %h und %b want %h 1", word_at(30), und_log[30], IDLE);
        end
        $display("[TB] disable: retrain=%h %h after=%h", word_at(0), word_at(10), word_at(30));
    endtask

    task automatic test_async_reset();
        start_link();
        tx_q = '{10'h2AA};
        run_edges(32);
        tests_run++;
        if ({DOUT, DIN_READY, UNDERRUN} !== 3'b111) begin
            tests_failed++;
            $display("FAIL areset_pre: got %b want 111", {DOUT, DIN_READY, UNDERRUN});
        end
        #2;
        CLR = 1'b1;
        #1;
        tests_run++;
        if ({DOUT, FRAME, DIN_READY, UNDERRUN} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL areset_async: got %b want 0000", {DOUT, FRAME, DIN_READY, UNDERRUN});
        end
        @(posedge C);
        #1;
        CLR   = 1'b0;
        TX_EN = 1'b0;
        $display("[TB] async_reset: outputs=%b", {DOUT, FRAME, DIN_READY, UNDERRUN});
    endtask

    initial begin
        test_reset();
        test_preamble();
        test_back_to_back();
        test_underrun();
        test_hold_full();
        test_disable();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
